// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile row packer.
// Byte-granular word math and the packer state encoding.
package tile_pkg;

    localparam int BYTES_PER_WORD = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROW,
        DONE
    } packer_state_t;

    // Number of 8-byte words needed to hold len bytes (len <= 66).
    function automatic logic [3:0] ceil_words(input logic [6:0] len);
        logic [6:0] t;
        t = len + 7'd7;
        return t[6:3];
    endfunction

    // Bytes kept in the final word of a row of tot bytes.
    function automatic logic [7:0] tail_mask(input logic [6:0] tot);
        logic [7:0] m;
        if (tot[2:0] == 3'd0) begin
            m = 8'hFF;
        end else begin
            m = (8'h01 << tot[2:0]) - 8'h01;
        end
        return m;
    endfunction

endpackage

// File: rtl/tile_pack_fifo.sv
// Small synchronous word FIFO between the mover and the packer.
// Extra pointer bit distinguishes full from empty.
module tile_pack_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update and storage write; clear only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_row_packer.sv
// Packs mover row words into scratchpad rows with left pad and tail mask.
// Optional write counter port enabled by TILE_ROW_PACKER_STATS_EN.
module tile_row_packer
    import tile_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  start,
    input  logic [5:0]            row_len,
    input  logic [1:0]            pad_first_col,
    input  logic                  pad_all,
    input  logic [9:0]            chan_num,
    input  logic [ADDR_WIDTH-1:0] base_addr_wr,
    input  logic [ADDR_WIDTH-1:0] stride_chan,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  data_consumed,
    output logic                  sp_wr_en,
    output logic [ADDR_WIDTH-1:0] sp_wr_addr,
    output logic [DATA_WIDTH-1:0] sp_wr_data,
    input  logic                  sp_wr_ready,
    output logic                  done
`ifdef TILE_ROW_PACKER_STATS_EN
    ,
    output logic [15:0]           stat_words_written
`endif
);

    packer_state_t         state_q;
    logic [5:0]            row_len_q;
    logic [1:0]            pad_q;
    logic                  pad_all_q;
    logic [9:0]            chan_num_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [3:0]            n_in_q;
    logic [3:0]            n_out_q;
    logic [7:0]            mask_q;
    logic [13:0]           need_q;
    logic [13:0]           acc_q;
    logic [3:0]            k_q;
    logic [9:0]            chan_q;
    logic [ADDR_WIDTH-1:0] off_q;
    logic [DATA_WIDTH-1:0] carry_q;
    logic                  dc_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  done_q;

    logic                  sclr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  accept;
    logic                  in_row;
    logic                  out_free;
    logic                  k_lt_out;
    logic                  from_fifo;
    logic                  emit;
    logic                  pop;
    logic                  last_k;
    logic                  row_end;
    logic                  last_row;
    logic [4:0]            sh;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] carry_nx;
    logic [DATA_WIDTH-1:0] word_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [6:0]            tot_c;
    logic [3:0]            n_in_c;

    assign sclr      = rst | clr;
    assign in_row    = (state_q == ROW);
    assign accept    = in_row & data_valid & ~fifo_full & ~dc_q &
                       (acc_q < need_q);
    assign out_free  = ~wr_en_q | sp_wr_ready;
    assign k_lt_out  = (k_q < n_out_q);
    assign from_fifo = ~pad_all_q & (k_q < n_in_q);
    assign emit      = in_row & out_free & k_lt_out &
                       (~from_fifo | ~fifo_empty);
    assign pop       = emit & from_fifo;
    assign last_k    = ((k_q + 4'd1) == n_out_q);
    assign row_end   = in_row & (~k_lt_out | (emit & last_k));
    assign last_row  = ((chan_q + 10'd1) == chan_num_q);

    assign sh        = {pad_q, 3'b000};
    assign shifted   = (fifo_head << sh) | carry_q;
    assign carry_nx  = (pad_q == 2'd0) ? '0 :
                       (fifo_head >> (7'(DATA_WIDTH) - {2'b00, sh}));
    assign addr_d    = base_q + off_q + ADDR_WIDTH'(k_q);

    assign tot_c     = {1'b0, row_len_q} + {5'b00000, pad_q};
    assign n_in_c    = pad_all_q ? 4'd0 : ceil_words({1'b0, row_len_q});

    tile_pack_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr_i   (sclr),
        .push_i  (accept),
        .data_i  (in_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Select the source of the next output word and zero its tail bytes.
    always_comb begin
        word_d = pad_all_q ? '0 : (from_fifo ? shifted : carry_q);
        if (last_k) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (!mask_q[b]) begin
                    word_d[8*b +: 8] = 8'h00;
                end
            end
        end
    end

    // Control FSM, input accounting and registered write port.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q    <= IDLE;
            row_len_q  <= '0;
            pad_q      <= '0;
            pad_all_q  <= 1'b0;
            chan_num_q <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            n_in_q     <= '0;
            n_out_q    <= '0;
            mask_q     <= '0;
            need_q     <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            chan_q     <= '0;
            off_q      <= '0;
            carry_q    <= '0;
            dc_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            dc_q   <= accept;
            done_q <= 1'b0;
            if (accept) begin
                acc_q <= acc_q + 14'd1;
            end
            if (emit) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_d;
                wr_data_q <= word_d;
                k_q       <= k_q + 4'd1;
                if (pop) begin
                    carry_q <= carry_nx;
                end
            end else if (sp_wr_ready) begin
                wr_en_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        row_len_q  <= row_len;
                        pad_q      <= pad_first_col;
                        pad_all_q  <= pad_all;
                        chan_num_q <= chan_num;
                        base_q     <= base_addr_wr;
                        stride_q   <= stride_chan;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    n_in_q  <= n_in_c;
                    n_out_q <= ceil_words(tot_c);
                    mask_q  <= tail_mask(tot_c);
                    need_q  <= 14'(n_in_c) * 14'(chan_num_q);
                    acc_q   <= '0;
                    k_q     <= '0;
                    chan_q  <= '0;
                    off_q   <= '0;
                    carry_q <= '0;
                    state_q <= (chan_num_q == 10'd0) ? DONE : ROW;
                end
                ROW: begin
                    if (row_end) begin
                        k_q     <= '0;
                        carry_q <= '0;
                        chan_q  <= chan_q + 10'd1;
                        off_q   <= off_q + stride_q;
                        if (last_row) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_free) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_consumed = dc_q;
    assign sp_wr_en      = wr_en_q;
    assign sp_wr_addr    = wr_addr_q;
    assign sp_wr_data    = wr_data_q;
    assign done          = done_q;

`ifdef TILE_ROW_PACKER_STATS_EN
    logic [15:0] stat_q;

    // Saturating count of writes the scratchpad has taken.
    always_ff @(posedge clk) begin
        if (sclr || start) begin
            stat_q <= '0;
        end else if (wr_en_q && sp_wr_ready && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_words_written = stat_q;
`endif

endmodule

// File: tb/tb_tile_row_packer.sv
// Directed bench for tile_row_packer: packing, pad, backpressure, wrap.
// A negedge monitor logs accepts, writes and done pulses.
module tb_tile_row_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  row_len = '0;
    logic [1:0]  pad_first_col = '0;
    logic        pad_all = 1'b0;
    logic [9:0]  chan_num = '0;
    logic [7:0]  base_addr_wr = '0;
    logic [7:0]  stride_chan = '0;
    logic        data_valid = 1'b0;
    logic [63:0] in_data;
    logic        data_consumed;
    logic        sp_wr_en;
    logic [7:0]  sp_wr_addr;
    logic [63:0] sp_wr_data;
    logic        sp_wr_ready = 1'b1;
    logic        done;
`ifdef TILE_ROW_PACKER_STATS_EN
    logic [15:0] stat_words_written;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int cons_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int src_base = 0;
    logic [63:0] src_words [16];
    logic [7:0]  wl_addr [64];
    logic [63:0] wl_data [64];

    assign in_data = src_words[4'(cons_cnt - src_base)];

    tile_row_packer dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .start         (start),
        .row_len       (row_len),
        .pad_first_col (pad_first_col),
        .pad_all       (pad_all),
        .chan_num      (chan_num),
        .base_addr_wr  (base_addr_wr),
        .stride_chan   (stride_chan),
        .data_valid    (data_valid),
        .in_data       (in_data),
        .data_consumed (data_consumed),
        .sp_wr_en      (sp_wr_en),
        .sp_wr_addr    (sp_wr_addr),
        .sp_wr_data    (sp_wr_data),
        .sp_wr_ready   (sp_wr_ready),
        .done          (done)
`ifdef TILE_ROW_PACKER_STATS_EN
        ,
        .stat_words_written (stat_words_written)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_consumed) cons_cnt = cons_cnt + 1;
        if (sp_wr_en && sp_wr_ready) begin
            wl_addr[wr_cnt % 64] = sp_wr_addr;
            wl_data[wr_cnt % 64] = sp_wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_src(input int seed);
        logic [63:0] w;
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'(seed + 8*i + b);
            src_words[i] = w;
        end
        src_base = cons_cnt;
    endtask

    task automatic kick(input logic [5:0] rl, input logic [1:0] pd,
                        input logic pa, input logic [9:0] cn,
                        input logic [7:0] ba, input logic [7:0] st);
        row_len = rl;
        pad_first_col = pd;
        pad_all = pa;
        chan_num = cn;
        base_addr_wr = ba;
        stride_chan = st;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        n_checks++;
        if (data_consumed !== 1'b0 || sp_wr_en !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctl got %b%b%b want 000",
                     data_consumed, sp_wr_en, done);
        end
        n_checks++;
        if (sp_wr_addr !== 8'h00 || sp_wr_data !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_bus got %h/%h want 0/0", sp_wr_addr, sp_wr_data);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic(input string nm, input logic [7:0] ba);
        int cb, wb, db;
        bit ok;
        logic [7:0]  ea [6];
        logic [63:0] ed [6];
        fill_src(16);
        cb = cons_cnt; wb = wr_cnt; db = done_cnt;
        ea = '{ba, ba + 8'd1, ba + 8'd2, ba + 8'd4, ba + 8'd5, ba + 8'd6};
        ed = '{src_words[0], src_words[1], src_words[2] & 64'hFFFF,
               src_words[3], src_words[4], src_words[5] & 64'hFFFF};
        data_valid = 1'b1;
        sp_wr_ready = 1'b1;
        kick(6'd18, 2'd0, 1'b0, 10'd2, ba, 8'd4);
        wait_done(db, 200, ok);
        data_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s_timeout got no done want done", nm);
        end
        n_checks++;
        if (cons_cnt - cb != 6) begin
            n_errors++;
            $display("FAIL %s_consumed got %0d want 6", nm, cons_cnt - cb);
        end
        n_checks++;
        if (wr_cnt - wb != 6) begin
            n_errors++;
            $display("FAIL %s_writes got %0d want 6", nm, wr_cnt - wb);
        end
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (wl_addr[(wb + j) % 64] !== ea[j] ||
                wl_data[(wb + j) % 64] !== ed[j]) begin
                n_errors++;
                $display("FAIL %s_w%0d got %h:%h want %h:%h", nm, j,
                         wl_addr[(wb + j) % 64], wl_data[(wb + j) % 64],
                         ea[j], ed[j]);
            end
        end
        n_checks++;
        if (done_cnt - db != 1) begin
            n_errors++;
            $display("FAIL %s_done got %0d want 1", nm, done_cnt - db);
        end
`ifdef TILE_ROW_PACKER_STATS_EN
        n_checks++;
        if (stat_words_written !== 16'd6) begin
            n_errors++;
            $display("FAIL %s_stat got %0d want 6", nm, stat_words_written);
        end
`endif
    endtask

    task automatic test_left_pad;
        int cb, wb, db;
        bit ok;
        logic [63:0] ed [3];
        fill_src(100);
        cb = cons_cnt; wb = wr_cnt; db = done_cnt;
        ed[0] = {src_words[0][55:0], 8'h00};
        ed[1] = {src_words[1][55:0], src_words[0][63:56]};
        ed[2] = {56'h0, src_words[1][63:56]};
        data_valid = 1'b1;
        kick(6'd16, 2'd1, 1'b0, 10'd1, 8'h10, 8'd0);
        wait_done(db, 200, ok);
        data_valid = 1'b0;
        n_checks++;
        if (!ok || cons_cnt - cb != 2 || wr_cnt - wb != 3) begin
            n_errors++;
            $display("FAIL lpad_counts got done=%0b cons=%0d wr=%0d want 1/2/3",
                     ok, cons_cnt - cb, wr_cnt - wb);
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (wl_addr[(wb + j) % 64] !== 8'(8'h10 + j) ||
                wl_data[(wb + j) % 64] !== ed[j]) begin
                n_errors++;
                $display("FAIL lpad_w%0d got %h:%h want %h:%h", j,
                         wl_addr[(wb + j) % 64], wl_data[(wb + j) % 64],
                         8'(8'h10 + j), ed[j]);
            end
        end
    endtask

    task automatic test_pad_all;
        int cb, wb, db;
        bit ok;
        logic [7:0] ea [6];
        ea = '{8'd32, 8'd33, 8'd34, 8'd36, 8'd37, 8'd38};
        fill_src(50);
        cb = cons_cnt; wb = wr_cnt; db = done_cnt;
        data_valid = 1'b1;
        kick(6'd18, 2'd0, 1'b1, 10'd2, 8'd32, 8'd4);
        wait_done(db, 200, ok);
        data_valid = 1'b0;
        n_checks++;
        if (cons_cnt - cb != 0) begin
            n_errors++;
            $display("FAIL padall_consumed got %0d want 0", cons_cnt - cb);
        end
        n_checks++;
        if (!ok || wr_cnt - wb != 6 || done_cnt - db != 1) begin
            n_errors++;
            $display("FAIL padall_counts got done=%0d wr=%0d want 1/6",
                     done_cnt - db, wr_cnt - wb);
        end
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (wl_addr[(wb + j) % 64] !== ea[j] ||
                wl_data[(wb + j) % 64] !== 64'h0) begin
                n_errors++;
                $display("FAIL padall_w%0d got %h:%h want %h:0", j,
                         wl_addr[(wb + j) % 64], wl_data[(wb + j) % 64], ea[j]);
            end
        end
    endtask

    task automatic test_backpressure;
        int cb, wb, db;
        bit ok;
        bit seen;
        fill_src(200);
        cb = cons_cnt; wb = wr_cnt; db = done_cnt;
        sp_wr_ready = 1'b0;
        data_valid = 1'b1;
        kick(6'd63, 2'd0, 1'b0, 10'd1, 8'd0, 8'd0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (sp_wr_en) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL bp_first_write got none want sp_wr_en");
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            n_checks++;
            if (sp_wr_en !== 1'b1 || sp_wr_addr !== 8'd0 ||
                sp_wr_data !== src_words[0]) begin
                n_errors++;
                $display("FAIL bp_hold%0d got %b %h:%h want 1 00:%h", i,
                         sp_wr_en, sp_wr_addr, sp_wr_data, src_words[0]);
            end
        end
        n_checks++;
        if (cons_cnt - cb != 1 + 4 || data_consumed !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_accepts got %0d dc=%b want 5 dc=0",
                     cons_cnt - cb, data_consumed);
        end
        sp_wr_ready = 1'b1;
        wait_done(db, 200, ok);
        data_valid = 1'b0;
        n_checks++;
        if (!ok || cons_cnt - cb != 8 || wr_cnt - wb != 8) begin
            n_errors++;
            $display("FAIL bp_counts got done=%0b cons=%0d wr=%0d want 1/8/8",
                     ok, cons_cnt - cb, wr_cnt - wb);
        end
        for (int j = 0; j < 8; j++) begin
            logic [63:0] e;
            e = (j == 7) ? (src_words[7] & 64'h00FF_FFFF_FFFF_FFFF) : src_words[j];
            n_checks++;
            if (wl_addr[(wb + j) % 64] !== 8'(j) || wl_data[(wb + j) % 64] !== e) begin
                n_errors++;
                $display("FAIL bp_w%0d got %h:%h want %h:%h", j,
                         wl_addr[(wb + j) % 64], wl_data[(wb + j) % 64], 8'(j), e);
            end
        end
    endtask

    task automatic test_zero_chan;
        int wb, db;
        bit ok;
        wb = wr_cnt; db = done_cnt;
        data_valid = 1'b1;
        kick(6'd18, 2'd0, 1'b0, 10'd0, 8'd0, 8'd0);
        wait_done(db, 50, ok);
        data_valid = 1'b0;
        n_checks++;
        if (!ok || wr_cnt - wb != 0 || done_cnt - db != 1) begin
            n_errors++;
            $display("FAIL zero_chan got done=%0d wr=%0d want 1/0",
                     done_cnt - db, wr_cnt - wb);
        end
    endtask

    task automatic test_mid_reset;
        int wb, db;
        bit seen;
        fill_src(16);
        wb = wr_cnt; db = done_cnt;
        data_valid = 1'b1;
        sp_wr_ready = 1'b1;
        kick(6'd18, 2'd0, 1'b0, 10'd2, 8'd32, 8'd4);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (wr_cnt - wb >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL mrst_progress got %0d writes want 2", wr_cnt - wb);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if (data_consumed !== 1'b0 || sp_wr_en !== 1'b0 || done !== 1'b0 ||
            sp_wr_addr !== 8'h00 || sp_wr_data !== 64'h0) begin
            n_errors++;
            $display("FAIL mrst_outputs got %b%b%b %h:%h want 000 00:0",
                     data_consumed, sp_wr_en, done, sp_wr_addr, sp_wr_data);
        end
        data_valid = 1'b0;
        repeat (20) tick;
        n_checks++;
        if (done_cnt != db) begin
            n_errors++;
            $display("FAIL mrst_no_done got %0d want 0", done_cnt - db);
        end
        test_basic("mrst_rerun", 8'd32);
    endtask

    initial begin
        test_reset;
        test_basic("basic", 8'd32);
        test_left_pad;
        test_pad_all;
        test_backpressure;
        test_basic("wrap", 8'd254);
        test_zero_chan;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
